// File: rtl/trng_collector_pkg.sv
// Shared types and defaults for the TRNG collector: FSM state encoding, default
// parameter values and state-to-core-control decode helpers.
package trng_collector_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WARMUP  = 3'd1,
    S_DISCARD = 3'd2,
    S_COLLECT = 3'd3,
    S_HOLD    = 3'd4,
    S_FAIL    = 3'd5
  } state_e;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_WARMUP_CYC  = 64;
  localparam int DEF_DISCARD_CYC = 4;
  localparam int DEF_REP_LIMIT   = 16;

  // Oscillators run in every state except IDLE and FAIL.
  function automatic logic osc_on(state_e s);
    return (s != S_IDLE) && (s != S_FAIL);
  endfunction

  function automatic logic sample_on(state_e s);
    return (s == S_DISCARD) || (s == S_COLLECT) || (s == S_HOLD);
  endfunction

endpackage

// File: rtl/trng_collector_if.sv
// Random-word output port of the TRNG collector.
// A word transfers on a rising clk edge where rnd_valid & rnd_ready; while rnd_valid
// is high and no transfer has happened, rnd_data is held stable and rnd_valid stays high.
interface trng_collector_if
  import trng_collector_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();
  logic [WIDTH-1:0] rnd_data;
  logic             rnd_valid;
  logic             rnd_ready;

  modport master (output rnd_data, output rnd_valid, input rnd_ready);
  modport slave  (input rnd_data, input rnd_valid, output rnd_ready);
endinterface

// File: rtl/trng_collector_vn_debias.sv
// Von Neumann extractor: pairs raw bits, emits the first bit of each 01/10 pair as a
// single-cycle pulse in the cycle the second bit is sampled.
module trng_collector_vn_debias (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic out_valid,
  output logic out_bit
);

  logic first_q, first_d;
  logic phase_q, phase_d;

  always_comb begin
    first_d = first_q;
    phase_d = phase_q;
    if (clr) begin
      first_d = 1'b0;
      phase_d = 1'b0;
    end else if (en) begin
      if (!phase_q) begin
        first_d = bit_in;
        phase_d = 1'b1;
      end else begin
        phase_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_q <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      first_q <= first_d;
      phase_q <= phase_d;
    end
  end

  assign out_valid = en & ~clr & phase_q & (first_q ^ bit_in);
  assign out_bit   = first_q;

endmodule

// File: rtl/trng_collector.sv
// Controller for the serial TRNG core: warm-up, pipeline flush, debiasing, word packing
// and a repetition-count health test on the raw bitstream.
module trng_collector
  import trng_collector_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int WARMUP_CYC  = DEF_WARMUP_CYC,
  parameter int DISCARD_CYC = DEF_DISCARD_CYC,
  parameter int REP_LIMIT   = DEF_REP_LIMIT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_i,
  input  logic               trng_bit_i,
  output logic               ro_en_o,
  output logic               start_o,
  output logic               health_fail_o,
  output logic               busy_o,
  output state_e             state_o,
  trng_collector_if.master   rnd
);

  localparam int WW = $clog2(WARMUP_CYC + 1);
  localparam int DW = $clog2(DISCARD_CYC + 1);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);

  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYC - 1);
  localparam logic [DW-1:0] DISC_LAST = DW'(DISCARD_CYC - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(WIDTH - 1);
  localparam logic [RW-1:0] REP_MAX   = RW'(REP_LIMIT);

  state_e           state_q, state_d;
  logic [WW-1:0]    warm_q, warm_d;
  logic [DW-1:0]    disc_q, disc_d;
  logic [BW-1:0]    bits_q, bits_d;
  logic [RW-1:0]    rep_q, rep_d, rep_nxt;
  logic             prev_q, prev_d;
  logic [WIDTH-2:0] sh_q, sh_d;
  logic [WIDTH-1:0] data_q, data_d, full;
  logic             valid_q, valid_d;
  logic             hf_q, hf_d;
  logic             ro_en_q, start_q, busy_q;
  logic             collecting, vn_valid, vn_bit;

  assign collecting = (state_q == S_COLLECT);

  trng_collector_vn_debias u_vn (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (!collecting),
    .en        (collecting),
    .bit_in    (trng_bit_i),
    .out_valid (vn_valid),
    .out_bit   (vn_bit)
  );

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    disc_d  = disc_q;
    bits_d  = bits_q;
    rep_d   = rep_q;
    prev_d  = prev_q;
    sh_d    = sh_q;
    data_d  = data_q;
    valid_d = valid_q;
    hf_d    = hf_q;
    full    = {vn_bit, sh_q};

    // A zero count marks the first sample after entering COLLECT.
    if (rep_q == '0 || trng_bit_i != prev_q) rep_nxt = RW'(1);
    else if (rep_q != REP_MAX)               rep_nxt = rep_q + 1'b1;
    else                                     rep_nxt = rep_q;

    case (state_q)
      S_IDLE: begin
        if (req_i) begin
          state_d = S_WARMUP;
          warm_d  = '0;
        end
      end
      S_WARMUP: begin
        if (!req_i) state_d = S_IDLE;
        else if (warm_q == WARM_LAST) begin
          state_d = S_DISCARD;
          disc_d  = '0;
        end else warm_d = warm_q + 1'b1;
      end
      S_DISCARD: begin
        if (!req_i) state_d = S_IDLE;
        else if (disc_q == DISC_LAST) begin
          state_d = S_COLLECT;
          bits_d  = '0;
          rep_d   = '0;
        end else disc_d = disc_q + 1'b1;
      end
      S_COLLECT: begin
        if (!req_i) state_d = S_IDLE;
        else begin
          rep_d  = rep_nxt;
          prev_d = trng_bit_i;
          // Health failure wins over a word completing on the same sample.
          if (rep_nxt == REP_MAX) begin
            state_d = S_FAIL;
            hf_d    = 1'b1;
          end else if (vn_valid) begin
            sh_d = full[WIDTH-1:1];
            if (bits_q == BITS_LAST) begin
              data_d  = full;
              valid_d = 1'b1;
              bits_d  = '0;
              state_d = S_HOLD;
            end else bits_d = bits_q + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (rnd.rnd_ready) begin
          valid_d = 1'b0;
          bits_d  = '0;
          rep_d   = '0;
          state_d = req_i ? S_COLLECT : S_IDLE;
        end
      end
      S_FAIL: begin
        if (!req_i) begin
          state_d = S_IDLE;
          hf_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      warm_q  <= '0;
      disc_q  <= '0;
      bits_q  <= '0;
      rep_q   <= '0;
      prev_q  <= 1'b0;
      sh_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      hf_q    <= 1'b0;
      ro_en_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      disc_q  <= disc_d;
      bits_q  <= bits_d;
      rep_q   <= rep_d;
      prev_q  <= prev_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      hf_q    <= hf_d;
      ro_en_q <= osc_on(state_d);
      start_q <= sample_on(state_d);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign rnd.rnd_data  = data_q;
  assign rnd.rnd_valid = valid_q;
  assign ro_en_o       = ro_en_q;
  assign start_o       = start_q;
  assign health_fail_o = hf_q;
  assign busy_o        = busy_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_trng_collector.sv
// Directed bench for trng_collector with WIDTH=8, WARMUP_CYC=4, DISCARD_CYC=4, REP_LIMIT=6.
module tb_trng_collector;
  import trng_collector_pkg::*;

  localparam int W  = 8;
  localparam int WU = 4;
  localparam int DC = 4;
  localparam int RL = 6;

  logic   clk      = 1'b0;
  logic   rst_n    = 1'b0;
  logic   req      = 1'b0;
  logic   trng_bit = 1'b0;
  logic   ro_en, start, hf, busy;
  state_e dbg_state;

  trng_collector_if #(.WIDTH(W)) bus ();

  trng_collector #(
    .WIDTH(W), .WARMUP_CYC(WU), .DISCARD_CYC(DC), .REP_LIMIT(RL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req),
    .trng_bit_i    (trng_bit),
    .ro_en_o       (ro_en),
    .start_o       (start),
    .health_fail_o (hf),
    .busy_o        (busy),
    .state_o       (dbg_state),
    .rnd           (bus.master)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_raw(input logic [63:0] bits, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      trng_bit = bits[first + i];
      step();
    end
  endtask

  // From IDLE with req=1: warm-up plus discard window, raw line held at 1.
  task automatic run_to_collect();
    trng_bit = 1'b1;
    repeat (1 + WU + DC) step();
  endtask

  // scoreboard
  task automatic check_word();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check_eq("word_data", 32'(bus.rnd_data), 32'(e));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rnd_ready = 1'b0;
    req = 1'b1;
    rst_n = 1'b0;
    repeat (3) step();
    check_eq("rst_ro_en", 32'(ro_en), 0);
    check_eq("rst_start", 32'(start), 0);
    check_eq("rst_busy",  32'(busy), 0);
    check_eq("rst_valid", 32'(bus.rnd_valid), 0);
    check_eq("rst_hf",    32'(hf), 0);
    check_eq("rst_data",  32'(bus.rnd_data), 0);

    // warm-up timing with req held through reset
    rst_n = 1'b1;
    step();
    check_eq("wu_ro_en", 32'(ro_en), 1);
    check_eq("wu_start", 32'(start), 0);
    check_eq("wu_busy",  32'(busy), 1);
    repeat (WU - 1) step();
    check_eq("wu_start_late", 32'(start), 0);
    check_eq("wu_busy_late",  32'(busy), 1);
    step();
    check_eq("start_rise", 32'(start), 1);

    // discard window of 1s, then 01,10,00,11 repeated -> 8'hAA
    trng_bit = 1'b1;
    repeat (DC) step();
    check_eq("in_collect", 32'(dbg_state), 32'(S_COLLECT));
    exp_q.push_back(8'hAA);
    drive_raw(64'hC6C6C6C6, 0, 27);
    check_eq("w1_not_yet", 32'(bus.rnd_valid), 0);
    drive_raw(64'hC6C6C6C6, 27, 1);
    check_eq("w1_valid", 32'(bus.rnd_valid), 1);
    check_word();
    for (int i = 0; i < 5; i++) begin
      trng_bit = 1'($urandom_range(0, 1));
      step();
      check_eq("hold_valid", 32'(bus.rnd_valid), 1);
      check_eq("hold_data",  32'(bus.rnd_data), 32'h0000_00AA);
    end
    bus.rnd_ready = 1'b1;
    step();
    bus.rnd_ready = 1'b0;
    check_eq("accept_valid", 32'(bus.rnd_valid), 0);
    check_eq("back_collect", 32'(dbg_state), 32'(S_COLLECT));

    // second word 10,10,01,01,01,01,10,10 -> 8'hC3; req dropped in HOLD
    exp_q.push_back(8'hC3);
    drive_raw(64'h5AA5, 0, 15);
    check_eq("w2_not_yet", 32'(bus.rnd_valid), 0);
    drive_raw(64'h5AA5, 15, 1);
    check_eq("w2_valid", 32'(bus.rnd_valid), 1);
    check_word();
    req = 1'b0;
    repeat (3) step();
    check_eq("hold_noreq_valid", 32'(bus.rnd_valid), 1);
    check_eq("hold_noreq_state", 32'(dbg_state), 32'(S_HOLD));
    bus.rnd_ready = 1'b1;
    step();
    bus.rnd_ready = 1'b0;
    check_eq("drain_valid", 32'(bus.rnd_valid), 0);
    check_eq("drain_busy",  32'(busy), 0);
    check_eq("drain_ro_en", 32'(ro_en), 0);
    check_eq("drain_start", 32'(start), 0);

    // req dropped with 5 of 8 bits packed
    req = 1'b1;
    run_to_collect();
    drive_raw(64'h199, 0, 10);
    check_eq("part_valid", 32'(bus.rnd_valid), 0);
    req = 1'b0;
    step();
    check_eq("part_state", 32'(dbg_state), 32'(S_IDLE));
    check_eq("part_busy",  32'(busy), 0);
    check_eq("part_data",  32'(bus.rnd_data), 32'h0000_00C3);
    repeat (4) step();
    check_eq("part_valid_after", 32'(bus.rnd_valid), 0);

    // repetition-count health failure
    req = 1'b1;
    run_to_collect();
    trng_bit = 1'b1;
    repeat (RL - 1) step();
    check_eq("rep_below_hf",    32'(hf), 0);
    check_eq("rep_below_start", 32'(start), 1);
    step();
    check_eq("rep_hf",    32'(hf), 1);
    check_eq("rep_ro_en", 32'(ro_en), 0);
    check_eq("rep_start", 32'(start), 0);
    check_eq("rep_state", 32'(dbg_state), 32'(S_FAIL));
    repeat (3) step();
    check_eq("fail_sticky", 32'(hf), 1);
    req = 1'b0;
    step();
    check_eq("fail_clear_hf",   32'(hf), 0);
    check_eq("fail_clear_busy", 32'(busy), 0);
    req = 1'b1;
    step();
    check_eq("restart_ro_en", 32'(ro_en), 1);
    check_eq("restart_state", 32'(dbg_state), 32'(S_WARMUP));

    // async reset while a word is held
    req = 1'b0;
    step();
    req = 1'b1;
    run_to_collect();
    exp_q.push_back(8'hFF);
    drive_raw(64'h5555, 0, 16);
    check_eq("w3_valid", 32'(bus.rnd_valid), 1);
    check_word();
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(bus.rnd_valid), 0);
    check_eq("arst_ro_en", 32'(ro_en), 0);
    check_eq("arst_start", 32'(start), 0);
    check_eq("arst_busy",  32'(busy), 0);
    check_eq("arst_data",  32'(bus.rnd_data), 0);
    check_eq("sb_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
